// File: rtl/freq_pkg.sv
// +----------------------------------------------------------------------------+
// | freq_pkg: shared constants, FSM state type and 7-segment decode helpers.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package freq_pkg;

  localparam int REF_FREQ = 1_000_000;

  localparam logic [6:0] C_SEG_0 = 7'h3F;
  localparam logic [6:0] C_SEG_1 = 7'h06;
  localparam logic [6:0] C_SEG_2 = 7'h5B;
  localparam logic [6:0] C_SEG_3 = 7'h4F;
  localparam logic [6:0] C_SEG_4 = 7'h66;
  localparam logic [6:0] C_SEG_5 = 7'h6D;
  localparam logic [6:0] C_SEG_6 = 7'h7D;
  localparam logic [6:0] C_SEG_7 = 7'h07;
  localparam logic [6:0] C_SEG_8 = 7'h7F;
  localparam logic [6:0] C_SEG_9 = 7'h6F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = C_SEG_0;
      4'd1:    s = C_SEG_1;
      4'd2:    s = C_SEG_2;
      4'd3:    s = C_SEG_3;
      4'd4:    s = C_SEG_4;
      4'd5:    s = C_SEG_5;
      4'd6:    s = C_SEG_6;
      4'd7:    s = C_SEG_7;
      4'd8:    s = C_SEG_8;
      4'd9:    s = C_SEG_9;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// +----------------------------------------------------------------------------+
// | bin2bcd_seq: sequential double-dabble converter with saturation to nines.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module bin2bcd_seq
  import freq_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                  ref_freq,
  input  logic                  nReset,
  input  logic                  start,
  input  logic [31:0]           bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int               BW      = 4 * DIGITS;
  localparam logic [63:0]      MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam logic [BW-1:0]    NINES   = {DIGITS{4'h9}};

  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_work;
  logic [31:0]   r_bin;
  logic [4:0]    r_iter;
  logic          r_ovf_work;
  logic [BW-1:0] r_bcd;
  logic          r_ovf;
  logic          r_done;
  logic [BW-1:0] w_adj;
  logic          w_too_big;

  assign w_too_big = ({32'd0, bin} > MAX_VAL);

  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge ref_freq or negedge nReset) begin
    if (!nReset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = w_too_big ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (r_iter == 5'd31) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ref_freq or negedge nReset) begin
    if (!nReset) begin
      r_work     <= '0;
      r_bin      <= '0;
      r_iter     <= '0;
      r_ovf_work <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_iter <= '0;
            if (w_too_big) begin
              r_work     <= NINES;
              r_ovf_work <= 1'b1;
            end else begin
              r_work     <= '0;
              r_bin      <= bin;
              r_ovf_work <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          {r_work, r_bin} <= {w_adj, r_bin} << 1;
          r_iter          <= r_iter + 5'd1;
        end
        ST_DONE: begin
          r_bcd  <= r_work;
          r_ovf  <= r_ovf_work;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: rtl/freq_bcd_display.sv
// +----------------------------------------------------------------------------+
// | freq_bcd_display: samples measured_freq, converts to BCD, scans 7-seg.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module freq_bcd_display
  import freq_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  ref_freq,
  input  logic                  nReset,
  input  logic [31:0]           measured_freq,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [31:0]       r_s1;
  logic [31:0]       r_s2;
  logic [31:0]       r_last;
  logic              w_start;
  logic              w_busy;
  logic [PW-1:0]     r_pre;
  logic              w_wrap;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_next;
  logic [IW-1:0]     w_msd;
  logic [3:0]        w_nib;
  logic              w_blank;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_dsel;

  // Only a value that held for two samples and differs from the last one is converted.
  assign w_start = (r_s1 == r_s2) && (r_s2 != r_last) && !w_busy;

  always_ff @(posedge ref_freq or negedge nReset) begin
    if (!nReset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_last <= '0;
    end else begin
      r_s1 <= measured_freq;
      r_s2 <= r_s1;
      if (w_start) r_last <= r_s2;
    end
  end

  bin2bcd_seq #(.DIGITS(DIGITS)) u_bin2bcd (
    .ref_freq (ref_freq),
    .nReset   (nReset),
    .start    (w_start),
    .bin      (r_s2),
    .busy     (w_busy),
    .done     (bcd_valid),
    .bcd      (bcd),
    .overflow (overflow)
  );

  assign w_wrap     = (r_pre == PW'(SCAN_DIV - 1));
  assign w_idx_next = !w_wrap ? r_idx :
                      (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);

  always_comb begin
    w_msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) w_msd = IW'(i);
    end
  end

  assign w_nib   = bcd[{w_idx_next, 2'b00} +: 4];
  assign w_blank = !overflow && (w_idx_next > w_msd);

  always_ff @(posedge ref_freq or negedge nReset) begin
    if (!nReset) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_seg  <= C_SEG_0;
      r_dsel <= DIGITS'(1);
    end else begin
      r_pre  <= w_wrap ? '0 : r_pre + PW'(1);
      r_idx  <= w_idx_next;
      r_seg  <= w_blank ? 7'h00 : seg_decode(w_nib);
      r_dsel <= DIGITS'(1) << w_idx_next;
    end
  end

  assign seg       = r_seg;
  assign digit_sel = r_dsel;

endmodule

`default_nettype wire

// File: tb/tb_freq_bcd_display.sv
// +----------------------------------------------------------------------------+
// | tb_freq_bcd_display: directed self-checking bench for freq_bcd_display.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_freq_bcd_display;

  logic        clk;
  logic        nReset;
  logic [31:0] measured_freq;
  logic [31:0] bcd;
  logic        bcd_valid;
  logic        overflow;
  logic [6:0]  seg;
  logic [7:0]  digit_sel;

  int checks;
  int errors;

  freq_bcd_display #(.DIGITS(8), .SCAN_DIV(4)) dut (
    .ref_freq      (clk),
    .nReset        (nReset),
    .measured_freq (measured_freq),
    .bcd           (bcd),
    .bcd_valid     (bcd_valid),
    .overflow      (overflow),
    .seg           (seg),
    .digit_sel     (digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = number of edges after the input change until bcd_valid is seen (0 = timeout).
  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (bcd_valid) begin
        n = i;
        break;
      end
    end
  endtask

  int         n;
  int         first_c;
  int         second_c;
  logic [31:0] first_v;
  logic [31:0] second_v;
  int         vcount;
  logic [7:0] prev_sel;
  logic [7:0] exp_sel;
  logic [6:0] exp_seg;
  int         synced;

  initial begin
    checks        = 0;
    errors        = 0;
    nReset        = 1'b0;
    measured_freq = 32'd0;
    for (int i = 0; i < 3; i++) step();

    check("rst_seg",   {57'd0, seg},       64'h3F);
    check("rst_dsel",  {56'd0, digit_sel}, 64'h01);
    check("rst_bcd",   {32'd0, bcd},       64'h0);
    check("rst_ovf",   {63'd0, overflow},  64'h0);
    check("rst_valid", {63'd0, bcd_valid}, 64'h0);

    nReset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("zero_no_conv", {32'd0, bcd}, 64'h0);

    // First capture edge is k (count 1); bcd_valid follows edge k+35 (count 36).
    measured_freq = 32'd1_000_000;
    wait_valid(60, n);
    check("norm_latency", 64'(n), 64'd36);
    check("norm_bcd", {32'd0, bcd}, 64'h01000000);
    check("norm_ovf", {63'd0, overflow}, 64'h0);
    step();
    check("norm_pulse_1cyc", {63'd0, bcd_valid}, 64'h0);

    measured_freq = 32'd123_456_789;
    wait_valid(60, n);
    check("sat_latency", 64'(n), 64'd4);
    check("sat_bcd", {32'd0, bcd}, 64'h99999999);
    check("sat_ovf", {63'd0, overflow}, 64'h1);

    measured_freq = 32'd42;
    wait_valid(60, n);
    check("r42_latency", 64'(n), 64'd36);
    check("r42_bcd", {32'd0, bcd}, 64'h00000042);
    check("r42_ovf", {63'd0, overflow}, 64'h0);

    measured_freq = 32'd50;
    wait_valid(60, n);
    check("r50_latency", 64'(n), 64'd36);
    check("r50_bcd", {32'd0, bcd}, 64'h00000050);
    step();
    synced   = 0;
    prev_sel = digit_sel;
    for (int i = 0; i < 64; i++) begin
      step();
      if (digit_sel == 8'h01 && prev_sel != 8'h01) begin
        synced = 1;
        break;
      end
      prev_sel = digit_sel;
    end
    check("scan_sync", 64'(synced), 64'd1);
    for (int slot = 0; slot < 9; slot++) begin
      exp_sel = 8'h01 << (slot % 8);
      exp_seg = ((slot % 8) == 0) ? 7'h3F : ((slot % 8) == 1) ? 7'h6D : 7'h00;
      for (int c = 0; c < 4; c++) begin
        check($sformatf("scan_dsel_s%0d_c%0d", slot, c), {56'd0, digit_sel}, {56'd0, exp_sel});
        check($sformatf("scan_seg_s%0d_c%0d", slot, c), {57'd0, seg}, {57'd0, exp_seg});
        step();
      end
    end

    // 200 arrives during the 100 conversion; it is picked up once the engine is idle.
    measured_freq = 32'd100;
    first_c  = 0;
    second_c = 0;
    first_v  = '0;
    second_v = '0;
    for (int i = 1; i <= 120; i++) begin
      step();
      if (i == 10) measured_freq = 32'd200;
      if (bcd_valid) begin
        if (first_c == 0) begin
          first_c = i;
          first_v = bcd;
        end else if (second_c == 0) begin
          second_c = i;
          second_v = bcd;
        end
      end
    end
    check("mid_first_cyc",  64'(first_c),  64'd36);
    check("mid_first_bcd",  {32'd0, first_v},  64'h100);
    check("mid_second_cyc", 64'(second_c), 64'd70);
    check("mid_second_bcd", {32'd0, second_v}, 64'h200);

    vcount = 0;
    for (int i = 0; i < 200; i++) begin
      measured_freq = (i % 2 == 0) ? 32'd5 : 32'd6;
      step();
      if (bcd_valid) vcount++;
    end
    check("toggle_no_valid", 64'(vcount), 64'd0);
    check("toggle_bcd_hold", {32'd0, bcd}, 64'h200);

    measured_freq = 32'd777;
    for (int i = 0; i < 10; i++) step();
    nReset        = 1'b0;
    measured_freq = 32'd0;
    #1;
    check("arst_bcd",   {32'd0, bcd},       64'h0);
    check("arst_ovf",   {63'd0, overflow},  64'h0);
    check("arst_valid", {63'd0, bcd_valid}, 64'h0);
    check("arst_seg",   {57'd0, seg},       64'h3F);
    check("arst_dsel",  {56'd0, digit_sel}, 64'h01);
    step();
    step();
    nReset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bcd_valid) vcount++;
    end
    check("post_rst_no_valid", 64'(vcount), 64'd0);
    check("post_rst_bcd", {32'd0, bcd}, 64'h0);

    measured_freq = 32'd777;
    wait_valid(60, n);
    check("post_rst_latency", 64'(n), 64'd36);
    check("post_rst_conv", {32'd0, bcd}, 64'h777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_bcd_display.md
# freq_bcd_display

Downstream display stage for the frequency measurer. It takes the 32-bit `measured_freq` result, re-times it into the `ref_freq` domain, and converts it to packed BCD with a sequential double-dabble engine. It then drives a multiplexed common-cathode 7-segment display with leading-zero blanking. Values above the display range saturate to all nines and raise an overflow flag.

## Interface
- `DIGITS`, 8, number of display digits (BCD range 0 .. 10^DIGITS−1)
- `SCAN_DIV`, 1000, `ref_freq` cycles per digit slot (1 ms at 1 MHz)
- `ref_freq` in 1: clock. One clock; all state is in this domain.
- `nReset` in 1: reset, asynchronous, active-low.
- `measured_freq` in 32: measurement result. It is produced in the `input_freq` domain and is not synchronous to `ref_freq`.
- `bcd` out 4*DIGITS: packed BCD of the last converted value; digit 0 is in bits [3:0].
- `bcd_valid` out 1: one-cycle pulse when `bcd` and `overflow` update.
- `overflow` out 1: last accepted value exceeded 10^DIGITS−1.
- `seg` out 7: segments, active-high; bit0=a … bit6=g.
- `digit_sel` out DIGITS: one-hot, active-high digit enable.

## Operation
- **Sampler:** registers `s1 <= measured_freq` and `s2 <= s1` every cycle. The value is *stable* when `s1 == s2`. A stable value is *new* when `s2 != last`, where `last` is the last accepted value.
- **FSM states:** IDLE, SHIFT, DONE.
  - **IDLE:** when the value is stable and new, set `last <= s2`.
    - If `s2 > 10^DIGITS−1`: go to DONE with the result forced to all digits = 9, overflow = 1.
    - Otherwise: load the shift register `{bcd_work = 0, bin = s2}`, set `iter = 0`, go to SHIFT.
  - **SHIFT:** each cycle, add 3 to every `bcd_work` digit ≥ 5, then shift `{bcd_work, bin}` left by 1 bit.
    - After 32 iterations (`iter` counts 0..31), go to DONE with overflow = 0.
  - **DONE:** register `bcd`/`overflow`, assert `bcd_valid` for that one cycle, return to IDLE.
- **Input changes during SHIFT/DONE:** ignored; there is no abort. On return to IDLE, the current stable value is evaluated normally, so no value is lost if it persists.
- **Input toggling every cycle:** never stable, so no conversion starts; outputs hold.
- **Initial state:** `last` resets to 0, so a zero input after reset does not trigger a conversion; `bcd` is already 0.
- **Scan:** a prescaler counts 0..SCAN_DIV−1. At its wrap, `idx` advances 0..DIGITS−1 and wraps to 0.
  - `digit_sel = 1 << idx`.
  - `seg` = decode of digit `idx` of `bcd`.
  - Blanking: a digit above the most significant non-zero digit gives `seg = 0`. Digit 0 is never blanked. Blanking is disabled while `overflow` = 1.
- **Decode:** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. The codes A–F are unreachable and decode to 0.

## Timing
- **Reset values:**
  - `bcd` = 0, `bcd_valid` = 0, `overflow` = 0
  - `digit_sel` = 1, `seg` = 7'h3F
  - `s1`, `s2`, `last` = 0; prescaler = 0; `idx` = 0; FSM in IDLE
- **Reset mid-operation:** all of the above take effect immediately (asynchronous), and any partial conversion is discarded.
- **Normal latency:** `measured_freq` changes before edge k.
  - Edge k: `s1` captures. Edge k+1: `s2` captures.
  - Edge k+2: IDLE accepts the value.
  - Edges k+3..k+34: 32 shifts.
  - Edge k+35: `bcd` updates, `bcd_valid` = 1 for one cycle.
- **Overflow latency:** accept at edge k+2; `bcd`, `overflow`, and `bcd_valid` update at edge k+3.
- **Output registering:** `seg` and `digit_sel` are registered. They change on the edge after the prescaler wrap or after a `bcd` update.
- **Conversion throughput:** at most one conversion per 34 cycles.

## Structure
- **Package `freq_pkg`:** the 7-segment code constants, a `seg_decode(logic [3:0])` function, the FSM state enum, and `REF_FREQ`.
- **Sub-module `bin2bcd_seq`:** the double-dabble FSM, with the ports `start`, `bin[31:0]`, `busy`, `done`, `bcd`, `overflow`.
- **Top level:** holds the sampler, the scan prescaler, and the display decode.

## Test plan
- **Reset:** assert `nReset` → `seg` = 7'h3F, `digit_sel` = 8'h01, `bcd` = 0, `overflow` = 0, `bcd_valid` = 0.
- **Normal conversion:** hold `measured_freq` = 1000000 → `bcd_valid` pulses 35 cycles after the change; `bcd` = 32'h01000000, `overflow` = 0.
- **Saturation:** `measured_freq` = 123456789 → 3 cycles later `bcd` = 32'h99999999, `overflow` = 1. Then apply 42 → `bcd` = 32'h00000042, `overflow` = 0.
- **Scan and blanking:** `SCAN_DIV` = 4, value 50.
  - `digit_sel` walks 01,02,04…80,01, advancing every 4 cycles.
  - `seg` = 3F on digit 0, 6D on digit 1, 00 on digits 2–7.
- **Change mid-conversion:** input 100, then 200 ten cycles later → `bcd_valid` twice, giving `bcd` = 32'h100 and then 32'h200.
- **Unstable input and mid-conversion reset:**
  - `measured_freq` alternating 5/6 every cycle → no `bcd_valid` for 200 cycles.
  - `nReset` pulsed during SHIFT → outputs reset immediately, with no `bcd_valid` afterwards unless the input is new.
